// File: rtl/atmega_eep_store_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : atmega_eep_store_pkg
//  Purpose  : Shared definitions for the EEPROM store controller: sequencer
//             state encoding and SD sector geometry.
//  Revision : 1.0 - initial release
// ============================================================================
package atmega_eep_store_pkg;

   // One SD sector is 512 bytes, addressed by a 9-bit buffer offset.
   localparam int SECTOR_BYTES = 512;
   localparam int SECTOR_AW    = 9;

   // Sequencer states: the REQ states hold sd_rd/sd_wr up until the host
   // acknowledges, and the XFER states follow sd_ack for one sector.
   localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
   localparam logic [2:0] ST_LD_REQ_ENC  = 3'd1;
   localparam logic [2:0] ST_LD_XFER_ENC = 3'd2;
   localparam logic [2:0] ST_SV_REQ_ENC  = 3'd3;
   localparam logic [2:0] ST_SV_XFER_ENC = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = ST_IDLE_ENC,
      ST_LD_REQ  = ST_LD_REQ_ENC,
      ST_LD_XFER = ST_LD_XFER_ENC,
      ST_SV_REQ  = ST_SV_REQ_ENC,
      ST_SV_XFER = ST_SV_XFER_ENC
   } state_t;

endpackage
`default_nettype wire

// File: rtl/atmega_eep_autosave_tmr.sv
`default_nettype none
// ============================================================================
//  Module   : atmega_eep_autosave_tmr
//  Purpose  : Autosave inactivity timer. Reloaded by every CPU write, counts
//             down while the RAM is dirty and flags expiry at zero.
//  Revision : 1.0 - initial release
// ============================================================================
module atmega_eep_autosave_tmr
   import atmega_eep_store_pkg::*;
#(
   parameter int AUTOSAVE_DLY = 8_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reload,
   input  logic run,
   output logic expired
);

   localparam int               CNT_W      = $clog2(AUTOSAVE_DLY + 1);
   localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(AUTOSAVE_DLY);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [CNT_W-1:0] count;

   // Reload on write; otherwise count down while dirty, saturating at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= RELOAD_VAL;
      end else if (reload) begin
         count <= RELOAD_VAL;
      end else if (run && (count != '0)) begin
         count <= count - CNT_ONE;
      end
   end

   assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/atmega_eep_store_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : atmega_eep_store_ctrl
//  Purpose  : Arbitrates the EEPROM backing RAM between the CPU-side EEPROM
//             peripheral and the host SD-image port. Loads the image on
//             mount, saves it on request or after write inactivity, and
//             stalls CPU accesses while a sector transfer owns the RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module atmega_eep_store_ctrl
   import atmega_eep_store_pkg::*;
#(
   parameter int EEP_SIZE     = 1024,
   parameter int ADDR_W       = 10,
   parameter int AUTOSAVE_DLY = 8_000_000,
   parameter int LBA_W        = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata,
   input  logic              img_mounted,
   input  logic              img_size_nz,
   input  logic              save_req,
   output logic [LBA_W-1:0]  sd_lba,
   output logic              sd_rd,
   output logic              sd_wr,
   input  logic              sd_ack,
   input  logic [8:0]        sd_buff_addr,
   input  logic [7:0]        sd_buff_dout,
   output logic [7:0]        sd_buff_din,
   input  logic              sd_buff_wr,
   output logic              busy,
   output logic              dirty
);

   localparam logic [LBA_W-1:0] LAST_LBA = LBA_W'(EEP_SIZE / SECTOR_BYTES - 1);
   localparam logic [LBA_W-1:0] LBA_ONE  = LBA_W'(1);

   state_t            state;
   logic              mounted;
   logic              pending;
   logic              granted;
   logic [ADDR_W-1:0] acc_addr;
   logic              acc_we;
   logic [7:0]        acc_wdata;
   logic [ADDR_W-1:0] xfer_addr;
   logic              expired;
   logic              mount_ev;
   logic              unmount_ev;
   logic              save_go;
   logic              cpu_grant;
   logic              last_sector;

   assign mount_ev    = img_mounted && img_size_nz;
   assign unmount_ev  = img_mounted && !img_size_nz;
   assign save_go     = mounted && (save_req || pending || (dirty && expired));
   assign last_sector = (sd_lba == LAST_LBA);
   // A mount/unmount event or a save start in the same cycle takes the RAM
   // away from the CPU, so the request simply waits.
   assign cpu_grant   = (state == ST_IDLE) && !img_mounted && !save_go &&
                        cpu_req && !granted;

   // Host-side RAM address: sector index above the 9-bit buffer offset.
   generate
      if (ADDR_W > SECTOR_AW) begin : g_multi_sector
         assign xfer_addr = {sd_lba[ADDR_W-SECTOR_AW-1:0], sd_buff_addr};
      end else begin : g_single_sector
         assign xfer_addr = sd_buff_addr[ADDR_W-1:0];
      end
   endgenerate

   atmega_eep_autosave_tmr #(
      .AUTOSAVE_DLY (AUTOSAVE_DLY)
   ) u_autosave_tmr (
      .clk     (clk),
      .rst_n   (rst_n),
      .reload  (cpu_grant && cpu_we),
      .run     (dirty),
      .expired (expired)
   );

   // Sequencer: transfer control, CPU grant/ack and mount/dirty bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sd_lba    <= '0;
         sd_rd     <= 1'b0;
         sd_wr     <= 1'b0;
         busy      <= 1'b0;
         dirty     <= 1'b0;
         mounted   <= 1'b0;
         pending   <= 1'b0;
         granted   <= 1'b0;
         cpu_ack   <= 1'b0;
         acc_addr  <= '0;
         acc_we    <= 1'b0;
         acc_wdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         acc_we  <= 1'b0;
         // The RAM sampled the granted address this edge; data is valid next.
         if (granted) begin
            granted <= 1'b0;
            cpu_ack <= 1'b1;
         end
         // A save that cannot start right now is remembered.
         if (save_req && !((state == ST_IDLE) && mounted && !img_mounted)) begin
            pending <= 1'b1;
         end
         if (unmount_ev) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            mounted <= 1'b0;
            pending <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (mount_ev) begin
                     state   <= ST_LD_REQ;
                     busy    <= 1'b1;
                     mounted <= 1'b1;
                     sd_lba  <= '0;
                     sd_rd   <= 1'b1;
                  end else if (save_go) begin
                     state   <= ST_SV_REQ;
                     busy    <= 1'b1;
                     sd_lba  <= '0;
                     sd_wr   <= 1'b1;
                     dirty   <= 1'b0;
                     pending <= 1'b0;
                  end else if (cpu_grant) begin
                     granted   <= 1'b1;
                     acc_addr  <= cpu_addr;
                     acc_we    <= cpu_we;
                     acc_wdata <= cpu_wdata;
                     if (cpu_we) begin
                        dirty <= 1'b1;
                     end
                  end
               end
               ST_LD_REQ: begin
                  if (sd_ack) begin
                     state <= ST_LD_XFER;
                     sd_rd <= 1'b0;
                  end
               end
               ST_LD_XFER: begin
                  if (!sd_ack) begin
                     if (last_sector) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        dirty <= 1'b0;
                     end else begin
                        state  <= ST_LD_REQ;
                        sd_lba <= sd_lba + LBA_ONE;
                        sd_rd  <= 1'b1;
                     end
                  end
               end
               ST_SV_REQ: begin
                  if (sd_ack) begin
                     state <= ST_SV_XFER;
                     sd_wr <= 1'b0;
                  end
               end
               ST_SV_XFER: begin
                  if (!sd_ack) begin
                     if (last_sector) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                     end else begin
                        state  <= ST_SV_REQ;
                        sd_lba <= sd_lba + LBA_ONE;
                        sd_wr  <= 1'b1;
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // RAM port mux: the host buffer drives the RAM during sector transfers,
   // the registered CPU access otherwise.
   always_comb begin
      ram_addr    = acc_addr;
      ram_we      = acc_we;
      ram_wdata   = acc_wdata;
      sd_buff_din = 8'h00;
      case (state)
         ST_LD_XFER: begin
            ram_addr  = xfer_addr;
            ram_we    = sd_buff_wr;
            ram_wdata = sd_buff_dout;
         end
         ST_SV_XFER: begin
            ram_addr    = xfer_addr;
            ram_we      = 1'b0;
            sd_buff_din = ram_rdata;
         end
         default: begin
         end
      endcase
   end

   assign cpu_rdata = cpu_ack ? ram_rdata : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_atmega_eep_store_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atmega_eep_store_ctrl
//  Purpose  : Directed self-checking bench for atmega_eep_store_ctrl with a
//             1-cycle-read RAM model and an inline SD host.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_atmega_eep_store_ctrl;

   localparam int EEP_SIZE     = 1024;
   localparam int ADDR_W       = 10;
   localparam int AUTOSAVE_DLY = 16;
   localparam int LBA_W        = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata, cpu_rdata;
   logic              cpu_ack;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_wdata, ram_rdata;
   logic              img_mounted, img_size_nz, save_req;
   logic [LBA_W-1:0]  sd_lba;
   logic              sd_rd, sd_wr, sd_ack;
   logic [8:0]        sd_buff_addr;
   logic [7:0]        sd_buff_dout, sd_buff_din;
   logic              sd_buff_wr;
   logic              busy, dirty;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ack_cnt  = 0;

   logic [7:0] lba_q[$];
   logic [7:0] data_q[$];
   logic [7:0] mem [0:EEP_SIZE-1];

   atmega_eep_store_ctrl #(
      .EEP_SIZE(EEP_SIZE), .ADDR_W(ADDR_W),
      .AUTOSAVE_DLY(AUTOSAVE_DLY), .LBA_W(LBA_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .img_mounted(img_mounted), .img_size_nz(img_size_nz), .save_req(save_req),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
      .busy(busy), .dirty(dirty)
   );

   always #5 clk = ~clk;

   // posedge index counter and acknowledge counter
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cpu_ack === 1'b1) ack_cnt <= ack_cnt + 1;
   end

   // single-port RAM, one-cycle registered read
   always @(posedge clk) begin
      if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0:       return sd_rd === 1'b1;
         1:       return sd_wr === 1'b1;
         2:       return cpu_ack === 1'b1;
         default: return busy === 1'b0;
      endcase
   endfunction

   // n = negedges waited until the condition holds, -1 on timeout
   task automatic wait_for(input int sel, input int limit, output int n);
      n = -1;
      for (int i = 0; i <= limit; i++) begin
         if (cond(sel)) begin
            n = i;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic expect_req(input int sel, input string tag, output int n);
      wait_for(sel, 60, n);
      check({tag, "_seen"}, 32'(n >= 0), 32'd1);
   endtask

   task automatic cpu_access(input logic we, input int addr, input logic [7:0] wd,
                             input string tag, output int t0, output int lat);
      int n;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = ADDR_W'(addr); cpu_wdata = wd;
      t0 = cyc;
      wait_for(2, 40, n);
      check({tag, "_ack_seen"}, 32'(n >= 0), 32'd1);
      lat = cyc - t0;
      if (!we) check({tag, "_rdata"}, 32'(cpu_rdata), 32'(data_q.pop_front()));
      cpu_req = 1'b0;
      @(negedge clk);
      check({tag, "_ack_pulse"}, 32'(cpu_ack), 32'd0);
   endtask

   // load sector: request must already be up; host writes one byte
   task automatic host_load(input int off, input logic [7:0] val, input string tag);
      logic [7:0] lba;
      lba = lba_q.pop_front();
      check({tag, "_lba"}, 32'(sd_lba), 32'(lba));
      sd_ack = 1'b1;
      @(negedge clk);
      check({tag, "_rd_drop"}, 32'(sd_rd), 32'd0);
      sd_buff_addr = 9'(off); sd_buff_dout = val; sd_buff_wr = 1'b1;
      #1;
      check({tag, "_ram_addr"}, 32'(ram_addr), 32'(lba) * 512 + 32'(off));
      @(negedge clk);
      sd_buff_wr = 1'b0; sd_ack = 1'b0;
      @(negedge clk);
   endtask

   // save sector: host reads one byte, optionally leaves sd_ack high
   task automatic host_save(input int off, input bit finish, input string tag);
      check({tag, "_lba"}, 32'(sd_lba), 32'(lba_q.pop_front()));
      sd_ack = 1'b1;
      @(negedge clk);
      check({tag, "_wr_drop"}, 32'(sd_wr), 32'd0);
      sd_buff_addr = 9'(off);
      @(negedge clk);
      check({tag, "_din"}, 32'(sd_buff_din), 32'(data_q.pop_front()));
      if (finish) begin
         sd_ack = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t0, lat, acks0, ack_cyc;
      for (int i = 0; i < EEP_SIZE; i++) mem[i] = 8'h00;
      rst_n = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      img_mounted = 0; img_size_nz = 0; save_req = 0; sd_ack = 0;
      sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 0;
      repeat (3) @(negedge clk);
      check("rst_flags", 32'({busy, dirty, sd_rd, sd_wr, cpu_ack, ram_we}), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // mount -> load lba 0 then 1
      lba_q.push_back(8'd0); lba_q.push_back(8'd1);
      img_mounted = 1; img_size_nz = 1;
      @(negedge clk);
      img_mounted = 0;
      check("mount_start", 32'({busy, sd_rd}), 32'b11);
      host_load(9, 8'h11, "ld0");
      expect_req(0, "ld1", n);
      host_load(3, 8'hA5, "ld1");
      wait_for(3, 10, n);
      check("ld_done", 32'(n >= 0), 32'd1);
      check("ld_ram515", 32'(mem[515]), 32'hA5);
      check("ld_dirty", 32'(dirty), 32'd0);

      // CPU read of 515
      data_q.push_back(8'hA5);
      cpu_access(1'b0, 515, 8'h00, "rd515", t0, lat);
      check("rd515_lat", 32'(lat), 32'd2);

      // CPU write then autosave after the inactivity delay
      cpu_access(1'b1, 7, 8'h3C, "wr7", t0, lat);
      check("wr7_dirty", 32'(dirty), 32'd1);
      expect_req(1, "as", n);
      check("as_latency", 32'(cyc - (t0 + 1)), 32'd17);
      check("as_dirty_clr", 32'(dirty), 32'd0);
      lba_q.push_back(8'd0); lba_q.push_back(8'd1);
      data_q.push_back(8'h3C); data_q.push_back(8'hA5);
      host_save(7, 1'b1, "as0");
      expect_req(1, "as1", n);
      host_save(3, 1'b1, "as1");

      // dirty write, then mount; save_req during load -> save right after
      cpu_access(1'b1, 40, 8'h5B, "wr40", t0, lat);
      lba_q.push_back(8'd0); lba_q.push_back(8'd1);
      img_mounted = 1; img_size_nz = 1;
      @(negedge clk);
      img_mounted = 0;
      expect_req(0, "rl0", n);
      save_req = 1;
      @(negedge clk);
      save_req = 0;
      host_load(9, 8'h5A, "rl0");
      expect_req(0, "rl1", n);
      host_load(3, 8'hA5, "rl1");
      check("rl_idle", 32'({busy, dirty}), 32'd0);
      lba_q.push_back(8'd0); lba_q.push_back(8'd1);
      data_q.push_back(8'h5A); data_q.push_back(8'hA5);
      wait_for(1, 10, n);
      check("pend_save_start", 32'(n), 32'd1);

      // CPU write held during the save
      acks0 = ack_cnt;
      cpu_req = 1; cpu_we = 1; cpu_addr = 10'd20; cpu_wdata = 8'h77;
      host_save(9, 1'b1, "ps0");
      expect_req(1, "ps1", n);
      host_save(3, 1'b1, "ps1");
      check("held_no_ack", 32'(ack_cnt), 32'(acks0));
      wait_for(2, 10, n);
      check("held_ack_seen", 32'(n >= 0), 32'd1);
      ack_cyc = cyc;
      check("held_ack_busy", 32'(busy), 32'd0);
      cpu_req = 0;
      @(negedge clk);
      check("held_dirty", 32'(dirty), 32'd1);
      check("held_ram20", 32'(mem[20]), 32'h77);
      expect_req(1, "as2", n);
      check("as2_latency", 32'(cyc - (ack_cyc - 1)), 32'd17);

      // unmount during SV_XFER
      lba_q.push_back(8'd0);
      data_q.push_back(8'h77);
      host_save(20, 1'b0, "um");
      img_mounted = 1; img_size_nz = 0;
      @(negedge clk);
      img_mounted = 0;
      check("um_abort", 32'({busy, sd_wr, dirty}), 32'd0);
      sd_ack = 0;
      @(negedge clk);

      // unmounted: save_req is only remembered, autosave cannot fire
      save_req = 1;
      @(negedge clk);
      save_req = 0;
      wait_for(1, 10, n);
      check("no_save_unmounted", 32'(n), 32'hFFFF_FFFF);
      cpu_access(1'b1, 30, 8'h42, "wr30", t0, lat);
      wait_for(1, 25, n);
      check("no_autosave_unmounted", 32'(n), 32'hFFFF_FFFF);

      // unmount during LD_XFER keeps dirty
      img_mounted = 1; img_size_nz = 1;
      @(negedge clk);
      img_mounted = 0;
      expect_req(0, "uml", n);
      sd_ack = 1;
      @(negedge clk);
      img_mounted = 1; img_size_nz = 0;
      @(negedge clk);
      img_mounted = 0;
      check("uml_abort", 32'({busy, sd_rd, dirty}), 32'b001);
      sd_ack = 0;
      @(negedge clk);

      // async reset in the middle of a host write
      img_mounted = 1; img_size_nz = 1;
      @(negedge clk);
      img_mounted = 0;
      expect_req(0, "rs", n);
      sd_ack = 1;
      @(negedge clk);
      sd_buff_addr = 9'd5; sd_buff_dout = 8'h99; sd_buff_wr = 1;
      #1;
      check("rs_pre_we", 32'({ram_we, dirty}), 32'b11);
      #1 rst_n = 1'b0;
      #1;
      check("rs_flags", 32'({busy, dirty, sd_rd, sd_wr, cpu_ack, ram_we}), 32'd0);
      check("rs_bus", 32'({ram_addr, sd_lba, sd_buff_din, cpu_rdata}), 32'd0);
      @(negedge clk);
      sd_ack = 0; sd_buff_wr = 0;
      rst_n = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
